uart_av_bridge: RTL and testbench
=================================

Name: uart_av_bridge

Overview:
- Byte-stream to Avalon-MM master bridge. Sits directly upstream of the universal register block and drives its avms_* slave port.
- Parses command frames from the UART RX byte stream and issues one single-cycle write or read per frame.
- Returns a write acknowledge or the read data as bytes on the UART TX byte stream.

Parameters:
- DW, 32, Avalon data width; must be a multiple of 8.
- AW, 16, Avalon address width; must be a multiple of 8.
- RD_LATENCY, 1, cycles from avm_read to valid avm_readdata; minimum 1.
- TIMEOUT_CYC, 100000, maximum idle cycles between bytes of one frame before the frame is discarded.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous reset, active-high
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  single-cycle strobe: rx_data_i is valid
- tx_data_o  out  8  byte to transmit
- tx_valid_o  out  1  tx_data_o is valid; held until accepted
- tx_ready_i  in  1  transmitter accepts the byte when tx_valid_o && tx_ready_i
- avm_address  out  AW  word address
- avm_byteenable  out  DW/8  byte lanes
- avm_write  out  1  write strobe
- avm_writedata  out  DW  write data
- avm_read  out  1  read strobe
- avm_readdata  in  DW  read data
- busy_o  out  1  high in every state except IDLE
- err_timeout_o  out  1  one-cycle pulse: frame discarded on timeout
- rx_overrun_o  out  1  one-cycle pulse: rx byte dropped while not accepting

Behaviour:
- Clock is clk_i. Reset is reset_i: asynchronous, active-high.
- Reset values: all outputs 0; FSM in IDLE; internal counters 0.
- Frame format:
  - Command byte: bit7 = 1 for write, 0 for read; bits[DW/8-1:0] = byteenable; other bits ignored.
  - Then AW/8 address bytes, MSB first.
  - Write frames only: then DW/8 data bytes, MSB first.
- FSM states: IDLE, ADDR, WDATA, WRITE, READ, RWAIT, RESP.
  - IDLE: on rx_valid_i, latch the command byte.
    - byteenable = 0: go to RESP and queue error byte 0xEE.
    - Otherwise: clear the byte counter and go to ADDR.
  - ADDR: shift each byte into the address register. After the AW/8-th byte go to WDATA (write) or READ (read).
  - WDATA: shift bytes into the data register. After the DW/8-th byte go to WRITE.
  - WRITE: avm_write = 1 for exactly one cycle, with address, byteenable and writedata valid. Queue ack byte 0xA5, then go to RESP.
  - READ: avm_read = 1 for exactly one cycle, then go to RWAIT.
  - RWAIT: count RD_LATENCY cycles from the read cycle. Capture avm_readdata in the cycle when the count reaches RD_LATENCY (RD_LATENCY=1: the cycle after avm_read). Then go to RESP with DW/8 bytes to send.
  - RESP: present bytes MSB first on tx_data_o with tx_valid_o high. Advance only on tx_ready_i. After the last accepted byte go to IDLE.
- Avalon idle rule: avm_address, avm_byteenable and avm_writedata are 0 in every cycle except the WRITE/READ access cycle. (The downstream block decodes read-valid from address/byteenable alone.)
- Latency: the access cycle is the cycle after the final frame byte's rx_valid_i.
- Timeout:
  - Applies in ADDR and WDATA only. The counter resets on every rx_valid_i.
  - When it reaches TIMEOUT_CYC: pulse err_timeout_o, discard the partial frame, go to IDLE. No TX output.
- Overrun: rx_valid_i in WRITE, READ, RWAIT or RESP drops the byte and pulses rx_overrun_o. The FSM is unaffected.
- Simultaneous events:
  - tx_ready_i on the last response byte plus rx_valid_i in the same cycle: the byte counts as overrun. IDLE accepts only from the next cycle.
  - rx_valid_i on the exact timeout cycle: the byte is accepted and the timeout is suppressed.
- tx_ready_i held low: RESP waits indefinitely. The timeout does not apply in RESP.
- Reset mid-frame or mid-response: immediate return to IDLE with all outputs 0. No partial Avalon access is ever issued.

Decomposition:
- Shared package uart_av_pkg holds:
  - the FSM state enum;
  - constants ACK_BYTE = 8'hA5, ERR_BYTE = 8'hEE and CMD_WR_BIT = 7.
- One sub-module, uart_av_timeout: a loadable down-counter with clear and expire pulse, reused by the UART RX framer.

Test Plan:
- Write frame 8F 00 01 DE AD BE EF → one cycle with avm_write=1, avm_address=0x0001, avm_byteenable=0xF, avm_writedata=0xDEADBEEF; then tx byte A5.
- Read frame 03 00 00 with avm_readdata=0x12345678 at RD_LATENCY=1 → avm_read for one cycle, avm_byteenable=0x3; tx bytes 12 34 56 78 in order; all Avalon outputs 0 outside the access cycle.
- Command 80 (byteenable 0) → no Avalon access; tx byte EE; FSM back in IDLE.
- Write frame stalled after the address bytes for TIMEOUT_CYC cycles → err_timeout_o pulses once; no avm_write. The next valid frame executes normally.
- tx_ready_i low for 50 cycles during a read response, with 3 rx bytes injected → tx_valid_o and tx_data_o stable throughout; rx_overrun_o pulses 3 times; full 4-byte response then delivered.
- reset_i asserted during WDATA → all outputs 0 asynchronously. After release, a fresh write frame completes with correct data.

Source files
------------

// File: rtl/uart_av_pkg.sv
// Shared types and constants for the UART byte-stream to Avalon-MM bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_av_pkg;

  // Frame parser / access sequencer states
  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WRITE,
    READ,
    RWAIT,
    RESP
  } state_t;

  localparam logic [7:0] ACK_BYTE   = 8'hA5;
  localparam logic [7:0] ERR_BYTE   = 8'hEE;
  localparam int         CMD_WR_BIT = 7;

endpackage

// File: rtl/uart_av_timeout.sv
// Inter-byte watchdog: reloadable down-counter that flags when a run of idle cycles reaches LOAD_VAL.
// Latency: o_expire is combinational in the LOAD_VAL-th enabled cycle after the last load.
// Backpressure: none; i_load has priority over i_clr, which has priority over counting.
module uart_av_timeout #(
  parameter int unsigned LOAD_VAL = 100000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic i_load,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = $clog2(LOAD_VAL + 1);

  logic [CW-1:0] r_cnt;

  // Reload on activity, clear when unused, otherwise count idle cycles down to zero
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                      r_cnt <= '0;
    else if (i_load)                  r_cnt <= CW'(LOAD_VAL);
    else if (i_clr)                   r_cnt <= '0;
    else if (i_en && (r_cnt != '0))   r_cnt <= r_cnt - CW'(1);
  end

  // Last allowed idle cycle with no fresh load: the window has run out
  assign o_expire = i_en && !i_load && (r_cnt == CW'(1));

endmodule

// File: rtl/uart_av_bridge.sv
// Parses command frames from an RX byte stream, issues one Avalon-MM write/read, returns ack/data bytes on TX.
// Latency: Avalon access in the cycle after the final frame byte; read data captured RD_LATENCY cycles after avm_read.
// Backpressure: TX held valid until tx_ready_i; RX has none, bytes arriving while busy are dropped with rx_overrun_o.
module uart_av_bridge
  import uart_av_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 16,
  parameter int RD_LATENCY  = 1,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [7:0]      rx_data_i,
  input  logic            rx_valid_i,
  output logic [7:0]      tx_data_o,
  output logic            tx_valid_o,
  input  logic            tx_ready_i,
  output logic [AW-1:0]   avm_address,
  output logic [DW/8-1:0] avm_byteenable,
  output logic            avm_write,
  output logic [DW-1:0]   avm_writedata,
  output logic            avm_read,
  input  logic [DW-1:0]   avm_readdata,
  output logic            busy_o,
  output logic            err_timeout_o,
  output logic            rx_overrun_o
);

  localparam int NB_D = DW / 8;
  localparam int NB_A = AW / 8;
  localparam int LW   = $clog2(RD_LATENCY + 1);

  state_t            r_state, w_next;
  logic              r_wr;
  logic [NB_D-1:0]   r_be;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_wdata;
  logic [DW-1:0]     r_tx_buf;
  logic [7:0]        r_byte_cnt;
  logic [7:0]        r_tx_cnt;
  logic [LW-1:0]     r_lat;

  logic w_in_frame, w_accept, w_tmo_en, w_expire;
  logic w_last_addr, w_last_data, w_lat_done, w_access;

  assign w_in_frame  = (r_state == ADDR) || (r_state == WDATA);
  assign w_accept    = rx_valid_i && ((r_state == IDLE) || w_in_frame);
  assign w_tmo_en    = w_in_frame && !rx_valid_i;
  assign w_last_addr = (r_byte_cnt == 8'(NB_A - 1));
  assign w_last_data = (r_byte_cnt == 8'(NB_D - 1));
  assign w_lat_done  = (r_lat == LW'(RD_LATENCY));

  uart_av_timeout #(
    .LOAD_VAL (TIMEOUT_CYC)
  ) u_timeout (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .i_load   (w_accept),
    .i_clr    (!w_in_frame),
    .i_en     (w_tmo_en),
    .o_expire (w_expire)
  );

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state: walk the frame, then access, then drain the response
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (rx_valid_i) w_next = (rx_data_i[NB_D-1:0] == '0) ? RESP : ADDR;
      ADDR:  begin
        if (rx_valid_i) begin
          if (w_last_addr) w_next = r_wr ? WDATA : READ;
        end else if (w_expire) begin
          w_next = IDLE;
        end
      end
      WDATA: begin
        if (rx_valid_i) begin
          if (w_last_data) w_next = WRITE;
        end else if (w_expire) begin
          w_next = IDLE;
        end
      end
      WRITE: w_next = RESP;
      READ:  w_next = RWAIT;
      RWAIT: if (w_lat_done) w_next = RESP;
      RESP:  if (tx_ready_i && (r_tx_cnt == 8'd1)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: command/address/data shift-in, read-latency count, response shift-out
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr       <= 1'b0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_tx_buf   <= '0;
      r_byte_cnt <= '0;
      r_tx_cnt   <= '0;
      r_lat      <= '0;
    end else begin
      case (r_state)
        IDLE: if (rx_valid_i) begin
          r_wr       <= rx_data_i[CMD_WR_BIT];
          r_be       <= rx_data_i[NB_D-1:0];
          r_addr     <= '0;
          r_wdata    <= '0;
          r_byte_cnt <= '0;
          if (rx_data_i[NB_D-1:0] == '0) begin
            r_tx_buf <= DW'(ERR_BYTE) << (DW - 8);
            r_tx_cnt <= 8'd1;
          end
        end
        ADDR: if (rx_valid_i) begin
          r_addr     <= (r_addr << 8) | AW'(rx_data_i);
          r_byte_cnt <= w_last_addr ? 8'd0 : r_byte_cnt + 8'd1;
        end
        WDATA: if (rx_valid_i) begin
          r_wdata    <= (r_wdata << 8) | DW'(rx_data_i);
          r_byte_cnt <= w_last_data ? 8'd0 : r_byte_cnt + 8'd1;
        end
        WRITE: begin
          r_tx_buf <= DW'(ACK_BYTE) << (DW - 8);
          r_tx_cnt <= 8'd1;
        end
        READ:  r_lat <= LW'(1);
        RWAIT: begin
          if (w_lat_done) begin
            r_tx_buf <= avm_readdata;
            r_tx_cnt <= 8'(NB_D);
          end else begin
            r_lat <= r_lat + LW'(1);
          end
        end
        RESP: if (tx_ready_i) begin
          r_tx_buf <= r_tx_buf << 8;
          r_tx_cnt <= r_tx_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Avalon bus is driven only during the single access cycle, zero otherwise
  assign w_access       = (r_state == WRITE) || (r_state == READ);
  assign avm_write      = (r_state == WRITE);
  assign avm_read       = (r_state == READ);
  assign avm_address    = w_access ? r_addr : '0;
  assign avm_byteenable = w_access ? r_be : '0;
  assign avm_writedata  = (r_state == WRITE) ? r_wdata : '0;

  assign tx_valid_o    = (r_state == RESP);
  assign tx_data_o     = (r_state == RESP) ? r_tx_buf[DW-1 -: 8] : 8'h00;
  assign busy_o        = (r_state != IDLE);
  assign err_timeout_o = w_expire;
  assign rx_overrun_o  = rx_valid_i && !((r_state == IDLE) || w_in_frame);

endmodule

// File: tb/tb_uart_av_bridge.sv
// Directed bench for uart_av_bridge: frame table plus timeout, backpressure, overrun and reset sequences.
// Latency: n/a.
// Backpressure: tx_ready_i driven by the stimulus.
module tb_uart_av_bridge;

  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int RDL = 1;
  localparam int TMO = 64;
  localparam logic [31:0] BAD_RD = 32'hBADC0FFE;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic [7:0]    rx_data_i = 8'h00;
  logic          rx_valid_i = 1'b0;
  logic [7:0]    tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_i = 1'b1;
  logic [AW-1:0] avm_address;
  logic [3:0]    avm_byteenable;
  logic          avm_write;
  logic [DW-1:0] avm_writedata;
  logic          avm_read;
  logic [DW-1:0] avm_readdata = BAD_RD;
  logic          busy_o;
  logic          err_timeout_o;
  logic          rx_overrun_o;

  uart_av_bridge #(
    .DW(DW), .AW(AW), .RD_LATENCY(RDL), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_read(avm_read), .avm_readdata(avm_readdata),
    .busy_o(busy_o), .err_timeout_o(err_timeout_o), .rx_overrun_o(rx_overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  int n_wr = 0, n_rd = 0, n_tmo = 0, n_ovr = 0, idle_viol = 0;
  int acc_cyc = 0, tmo_cyc = 0, last_cyc = 0;
  logic [15:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;
  logic [31:0] cur_rdata = 32'h0;
  logic [7:0]  txq[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Bus monitor: count accesses/pulses, capture access fields, collect accepted TX bytes
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (!avm_write && !avm_read &&
          (avm_address != '0 || avm_byteenable != '0 || avm_writedata != '0)) idle_viol++;
      if (avm_write) begin
        n_wr++; cap_addr = avm_address; cap_be = avm_byteenable;
        cap_wdata = avm_writedata; acc_cyc = cyc;
      end
      if (avm_read) begin
        n_rd++; cap_addr = avm_address; cap_be = avm_byteenable; acc_cyc = cyc;
      end
      if (tx_valid_o && tx_ready_i) txq.push_back(tx_data_o);
      if (err_timeout_o) begin n_tmo++; tmo_cyc = cyc; end
      if (rx_overrun_o) n_ovr++;
    end
  end

  // Slave model: read data valid only in the cycle RD_LATENCY(=1) after avm_read
  always @(negedge clk_i) begin
    if (avm_read) begin
      @(posedge clk_i); #1 avm_readdata = cur_rdata;
      @(posedge clk_i); #1 avm_readdata = BAD_RD;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called and returning at posedge+1; byte is live for exactly one cycle
  task automatic send_byte(input logic [7:0] b);
    rx_data_i = b; rx_valid_i = 1'b1; last_cyc = cyc;
    @(posedge clk_i); #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy_o && k < 200) begin @(posedge clk_i); #1; k++; end
    chk({nm, " idle"}, busy_o, 1'b0);
  endtask

  typedef struct {
    logic [55:0] frame;
    int          nb;
    logic [31:0] rdata;
    int          exp_wr;
    int          exp_rd;
    logic [15:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    int          exp_ntx;
    logic [31:0] exp_tx;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input string nm);
    int w0, r0, o0;
    logic [31:0] tv;
    w0 = n_wr; r0 = n_rd; o0 = n_ovr;
    txq.delete();
    cur_rdata = v.rdata;
    for (int i = 0; i < v.nb; i++) send_byte(v.frame[8*(v.nb-1-i) +: 8]);
    wait_idle(nm);
    chk({nm, " writes"}, n_wr - w0, v.exp_wr);
    chk({nm, " reads"},  n_rd - r0, v.exp_rd);
    chk({nm, " overruns"}, n_ovr - o0, 0);
    if (v.exp_wr + v.exp_rd == 1) begin
      chk({nm, " addr"}, cap_addr, v.exp_addr);
      chk({nm, " be"}, cap_be, v.exp_be);
      chk({nm, " access latency"}, acc_cyc - last_cyc, 1);
    end
    if (v.exp_wr == 1) chk({nm, " wdata"}, cap_wdata, v.exp_wdata);
    chk({nm, " tx count"}, txq.size(), v.exp_ntx);
    tv = '0;
    foreach (txq[i]) tv = {tv[23:0], txq[i]};
    chk({nm, " tx bytes"}, tv, v.exp_tx);
  endtask

  initial begin
    int t0, w0, r0, o0, k, unstable, L;
    logic [7:0]  d0;
    logic [31:0] tv;

    vecs[0] = '{frame:56'h8F0001DEADBEEF, nb:7, rdata:32'h0, exp_wr:1, exp_rd:0,
                exp_addr:16'h0001, exp_be:4'hF, exp_wdata:32'hDEADBEEF, exp_ntx:1, exp_tx:32'hA5};
    vecs[1] = '{frame:56'h030000, nb:3, rdata:32'h12345678, exp_wr:0, exp_rd:1,
                exp_addr:16'h0000, exp_be:4'h3, exp_wdata:32'h0, exp_ntx:4, exp_tx:32'h12345678};
    vecs[2] = '{frame:56'h80, nb:1, rdata:32'h0, exp_wr:0, exp_rd:0,
                exp_addr:16'h0, exp_be:4'h0, exp_wdata:32'h0, exp_ntx:1, exp_tx:32'hEE};
    vecs[3] = '{frame:56'h85ABCD00001111, nb:7, rdata:32'h0, exp_wr:1, exp_rd:0,
                exp_addr:16'hABCD, exp_be:4'h5, exp_wdata:32'h00001111, exp_ntx:1, exp_tx:32'hA5};
    vecs[4] = '{frame:56'h7C00FF, nb:3, rdata:32'hCAFEF00D, exp_wr:0, exp_rd:1,
                exp_addr:16'h00FF, exp_be:4'hC, exp_wdata:32'h0, exp_ntx:4, exp_tx:32'hCAFEF00D};
    vecs[5] = '{frame:56'h00, nb:1, rdata:32'h0, exp_wr:0, exp_rd:0,
                exp_addr:16'h0, exp_be:4'h0, exp_wdata:32'h0, exp_ntx:1, exp_tx:32'hEE};
    vecs[6] = '{frame:56'hF1800001020304, nb:7, rdata:32'h0, exp_wr:1, exp_rd:0,
                exp_addr:16'h8000, exp_be:4'h1, exp_wdata:32'h01020304, exp_ntx:1, exp_tx:32'hA5};

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("reset ctrl", {tx_data_o, tx_valid_o, avm_write, avm_read, busy_o, err_timeout_o, rx_overrun_o}, 0);
    chk("reset bus", {avm_address, avm_byteenable, avm_writedata}, 0);
    @(posedge clk_i); #1 reset_i = 1'b0;
    @(posedge clk_i); #1;

    // Frame table
    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Write frame stalled after the address bytes
    t0 = n_tmo; w0 = n_wr; txq.delete();
    send_byte(8'h8F); send_byte(8'h12); send_byte(8'h34);
    L = last_cyc;
    repeat (TMO + 10) begin @(posedge clk_i); #1; end
    chk("tmo pulses", n_tmo - t0, 1);
    chk("tmo cycle", tmo_cyc - L, TMO);
    chk("tmo no write", n_wr - w0, 0);
    chk("tmo no tx", txq.size(), 0);
    chk("tmo idle", busy_o, 1'b0);
    run_vec(vecs[0], "after_tmo");

    // Byte on the exact timeout cycle is accepted
    t0 = n_tmo; r0 = n_rd; cur_rdata = 32'h55AA55AA;
    send_byte(8'h03); send_byte(8'h00);
    repeat (TMO - 1) begin @(posedge clk_i); #1; end
    send_byte(8'h10);
    wait_idle("tmo_edge");
    chk("tmo_edge no pulse", n_tmo - t0, 0);
    chk("tmo_edge read", n_rd - r0, 1);
    chk("tmo_edge addr", cap_addr, 16'h0010);

    // Read response under TX backpressure with injected RX bytes
    tx_ready_i = 1'b0; o0 = n_ovr; w0 = n_wr; r0 = n_rd; txq.delete();
    cur_rdata = 32'h0A0B0C0D;
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h04);
    k = 0;
    while (!tx_valid_o && k < 20) begin @(posedge clk_i); #1; k++; end
    chk("bp tx_valid", tx_valid_o, 1'b1);
    d0 = tx_data_o;
    chk("bp first byte", d0, 8'h0A);
    unstable = 0;
    for (int c = 0; c < 50; c++) begin
      if (c == 10 || c == 25 || c == 40) begin rx_data_i = 8'h8F; rx_valid_i = 1'b1; end
      @(posedge clk_i); #1;
      rx_valid_i = 1'b0;
      if (!tx_valid_o || tx_data_o !== d0) unstable++;
    end
    chk("bp stable", unstable, 0);
    chk("bp overruns", n_ovr - o0, 3);
    tx_ready_i = 1'b1;
    wait_idle("bp");
    chk("bp tx count", txq.size(), 4);
    tv = '0;
    foreach (txq[i]) tv = {tv[23:0], txq[i]};
    chk("bp tx bytes", tv, 32'h0A0B0C0D);
    chk("bp accesses", (n_wr - w0) * 16 + (n_rd - r0), 1);

    // Last response byte accepted together with an RX byte
    tx_ready_i = 1'b0;
    send_byte(8'h80);
    chk("sim in resp", tx_valid_o, 1'b1);
    o0 = n_ovr;
    tx_ready_i = 1'b1; rx_data_i = 8'h83; rx_valid_i = 1'b1;
    @(posedge clk_i); #1;
    rx_valid_i = 1'b0;
    chk("sim overrun", n_ovr - o0, 1);
    chk("sim not accepted", busy_o, 1'b0);
    txq.delete();

    // Reset during WDATA
    w0 = n_wr;
    send_byte(8'h8F); send_byte(8'h00); send_byte(8'h02); send_byte(8'hDE); send_byte(8'hAD);
    chk("rst pre busy", busy_o, 1'b1);
    reset_i = 1'b1; #2;
    chk("rst async ctrl", {tx_data_o, tx_valid_o, avm_write, avm_read, busy_o, err_timeout_o, rx_overrun_o}, 0);
    chk("rst async bus", {avm_address, avm_byteenable, avm_writedata}, 0);
    @(posedge clk_i); #1 reset_i = 1'b0;
    @(posedge clk_i); #1;
    chk("rst no write", n_wr - w0, 0);
    run_vec(vecs[0], "after_rst");

    chk("avalon idle rule", idle_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
